// File: rtl/fwd_pkg.sv
// Shared encodings and helpers for the forwarding / load-use hazard unit.
// Forward-select codes, per-stage control tag and counter-increment width.
package fwd_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Control part of a pipeline tag; addresses are parameter-sized and live beside it.
  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
  } tag_ctl_t;

  // Bits needed to hold a per-cycle increment of 0..nsrc.
  function automatic int sat_add_w(input int nsrc);
    return $clog2(nsrc + 1);
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding resolution: compares one EX source against MEM/WB
// destinations, applies MEM-over-WB priority and drives the operand mux.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic          ex_valid,
  input  logic          ex_used,
  input  logic [AW-1:0] ex_src,
  input  logic          mem_valid,
  input  logic          mem_wr,
  input  logic          mem_load,
  input  logic [AW-1:0] mem_dst,
  input  logic          wb_valid,
  input  logic          wb_wr,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] rf_data,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] wb_data,
  output logic [1:0]    sel,
  output logic [DW-1:0] op
);

  logic active;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    active  = ex_valid && ex_used && !((ZERO_REG != 0) && (ex_src == '0));
    // A load in MEM has no data yet; the one-cycle stall keeps it from being needed.
    mem_hit = mem_valid && mem_wr && !mem_load && (mem_dst == ex_src);
    wb_hit  = wb_valid && wb_wr && (wb_dst == ex_src);

    sel = FWD_RF;
    if (active) begin
      if (mem_hit) begin
        sel = FWD_MEM;
      end else if (wb_hit) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    case (sel)
      FWD_MEM: op = mem_data;
      FWD_WB:  op = wb_data;
      default: op = rf_data;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks EX/MEM/WB destination tags,
// resolves NSRC operands, stalls on load-use, honours flush, counts events.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int NSRC     = 2,
  parameter int CW       = 16,
  parameter int ZERO_REG = 1
) (
  input  logic                 CLOCK,
  input  logic                 in_rst,
  input  logic                 in_id_valid,
  input  logic [NSRC*AW-1:0]   in_id_src,
  input  logic [NSRC-1:0]      in_id_src_used,
  input  logic [AW-1:0]        in_id_dst,
  input  logic                 in_id_wr,
  input  logic                 in_id_load,
  input  logic                 in_flush,
  input  logic [NSRC*DW-1:0]   in_ex_rf_data,
  input  logic [DW-1:0]        in_mem_data,
  input  logic [DW-1:0]        in_wb_data,
  output logic                 out_stall,
  output logic [NSRC*2-1:0]    out_fwd_sel,
  output logic [NSRC*DW-1:0]   out_op,
  output logic [CW-1:0]        out_stall_cnt,
  output logic [CW-1:0]        out_fwd_cnt
);

  localparam int FW = sat_add_w(NSRC);

  tag_ctl_t              ex_ctl_reg;
  logic [NSRC*AW-1:0]    ex_src_reg;
  logic [NSRC-1:0]       ex_used_reg;
  logic [AW-1:0]         ex_dst_reg;
  tag_ctl_t              mem_ctl_reg;
  logic [AW-1:0]         mem_dst_reg;
  logic                  wb_valid_reg;
  logic                  wb_wr_reg;
  logic [AW-1:0]         wb_dst_reg;
  logic [CW-1:0]         stall_cnt_reg;
  logic [CW-1:0]         fwd_cnt_reg;

  logic [NSRC-1:0]       id_hit;
  logic                  ex_dst_zero;
  logic                  stall;
  logic [FW-1:0]         fwd_events;
  logic [CW:0]           stall_sum;
  logic [CW+FW-1:0]      fwd_sum;
  logic [CW-1:0]         stall_cnt_next;
  logic [CW-1:0]         fwd_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign id_hit[gi] = in_id_src_used[gi] && (in_id_src[gi*AW +: AW] == ex_dst_reg);

      fwd_operand_sel #(
        .DW       (DW),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
      ) u_sel (
        .ex_valid  (ex_ctl_reg.valid),
        .ex_used   (ex_used_reg[gi]),
        .ex_src    (ex_src_reg[gi*AW +: AW]),
        .mem_valid (mem_ctl_reg.valid),
        .mem_wr    (mem_ctl_reg.wr),
        .mem_load  (mem_ctl_reg.load),
        .mem_dst   (mem_dst_reg),
        .wb_valid  (wb_valid_reg),
        .wb_wr     (wb_wr_reg),
        .wb_dst    (wb_dst_reg),
        .rf_data   (in_ex_rf_data[gi*DW +: DW]),
        .mem_data  (in_mem_data),
        .wb_data   (in_wb_data),
        .sel       (out_fwd_sel[gi*2 +: 2]),
        .op        (out_op[gi*DW +: DW])
      );
    end
  endgenerate

  // A load in EX feeding the ID instruction must wait one cycle for WB forwarding.
  assign ex_dst_zero = (ZERO_REG != 0) && (ex_dst_reg == '0);
  assign stall = in_id_valid && !in_flush && ex_ctl_reg.valid && ex_ctl_reg.load &&
                 ex_ctl_reg.wr && (|id_hit) && !ex_dst_zero;
  assign out_stall = stall;

  always_comb begin
    fwd_events = '0;
    for (int k = 0; k < NSRC; k++) begin
      fwd_events = fwd_events + FW'(out_fwd_sel[k*2 +: 2] != FWD_RF);
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_sum      = {1'b0, stall_cnt_reg} + (CW+1)'(stall);
    stall_cnt_next = stall_sum[CW] ? {CW{1'b1}} : stall_sum[CW-1:0];
    fwd_sum        = {{FW{1'b0}}, fwd_cnt_reg} + (CW+FW)'(fwd_events);
    fwd_cnt_next   = (fwd_sum > {{FW{1'b0}}, {CW{1'b1}}}) ? {CW{1'b1}} : fwd_sum[CW-1:0];
  end

  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      ex_ctl_reg    <= '0;
      ex_src_reg    <= '0;
      ex_used_reg   <= '0;
      ex_dst_reg    <= '0;
      mem_ctl_reg   <= '0;
      mem_dst_reg   <= '0;
      wb_valid_reg  <= 1'b0;
      wb_wr_reg     <= 1'b0;
      wb_dst_reg    <= '0;
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      wb_valid_reg <= mem_ctl_reg.valid;
      wb_wr_reg    <= mem_ctl_reg.wr;
      wb_dst_reg   <= mem_dst_reg;
      mem_ctl_reg  <= ex_ctl_reg;
      mem_dst_reg  <= ex_dst_reg;
      if (stall || in_flush) begin
        ex_ctl_reg <= '0;
      end else begin
        ex_ctl_reg.valid <= in_id_valid;
        ex_ctl_reg.wr    <= in_id_wr;
        ex_ctl_reg.load  <= in_id_load;
        ex_src_reg       <= in_id_src;
        ex_used_reg      <= in_id_src_used;
        ex_dst_reg       <= in_id_dst;
      end
      stall_cnt_reg <= stall_cnt_next;
      fwd_cnt_reg   <= fwd_cnt_next;
    end
  end

  assign out_stall_cnt = stall_cnt_reg;
  assign out_fwd_cnt   = fwd_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit (NSRC=2, DW=16, AW=4, CW=4).
// Each cycle pushes the expected outputs when ID is driven, then pops and checks.
module tb_fwd_hazard_unit;

  logic        CLOCK;
  logic        in_rst;
  logic        in_id_valid;
  logic [7:0]  in_id_src;
  logic [1:0]  in_id_src_used;
  logic [3:0]  in_id_dst;
  logic        in_id_wr;
  logic        in_id_load;
  logic        in_flush;
  logic [31:0] in_ex_rf_data;
  logic [15:0] in_mem_data;
  logic [15:0] in_wb_data;
  logic        out_stall;
  logic [3:0]  out_fwd_sel;
  logic [31:0] out_op;
  logic [3:0]  out_stall_cnt;
  logic [3:0]  out_fwd_cnt;

  fwd_hazard_unit #(
    .DW(16), .AW(4), .NSRC(2), .CW(4), .ZERO_REG(1)
  ) dut (
    .CLOCK          (CLOCK),
    .in_rst         (in_rst),
    .in_id_valid    (in_id_valid),
    .in_id_src      (in_id_src),
    .in_id_src_used (in_id_src_used),
    .in_id_dst      (in_id_dst),
    .in_id_wr       (in_id_wr),
    .in_id_load     (in_id_load),
    .in_flush       (in_flush),
    .in_ex_rf_data  (in_ex_rf_data),
    .in_mem_data    (in_mem_data),
    .in_wb_data     (in_wb_data),
    .out_stall      (out_stall),
    .out_fwd_sel    (out_fwd_sel),
    .out_op         (out_op),
    .out_stall_cnt  (out_stall_cnt),
    .out_fwd_cnt    (out_fwd_cnt)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  typedef struct {
    string       tag;
    logic        stall;
    logic [3:0]  sel;
    logic [31:0] op;
    logic [3:0]  scnt;
    logic [3:0]  fcnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int exp_scnt = 0;
  int exp_fcnt = 0;
  logic [15:0] mem_next;
  logic [15:0] wb_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // One pipeline cycle: drive ID, queue the expectation, sample 1 ns later.
  task automatic cyc(input string tag, input logic v, input logic [3:0] s0, input logic [3:0] s1,
                     input logic [1:0] used, input logic [3:0] dst, input logic wr,
                     input logic ld, input logic fl, input logic exp_stall,
                     input logic [3:0] exp_sel);
    exp_t e;
    exp_t got;
    int nfwd;
    @(negedge CLOCK);
    in_id_valid    = v;
    in_id_src      = {s1, s0};
    in_id_src_used = used;
    in_id_dst      = dst;
    in_id_wr       = wr;
    in_id_load     = ld;
    in_flush       = fl;
    in_ex_rf_data  = $urandom;
    in_mem_data    = mem_next;
    in_wb_data     = wb_next;
    e.tag   = tag;
    e.stall = exp_stall;
    e.sel   = exp_sel;
    nfwd    = 0;
    for (int k = 0; k < 2; k++) begin
      case (exp_sel[k*2 +: 2])
        2'b01:   begin e.op[k*16 +: 16] = in_mem_data; nfwd++; end
        2'b10:   begin e.op[k*16 +: 16] = in_wb_data;  nfwd++; end
        default: e.op[k*16 +: 16] = in_ex_rf_data[k*16 +: 16];
      endcase
    end
    e.scnt = 4'(exp_scnt);
    e.fcnt = 4'(exp_fcnt);
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".stall"}, 32'(out_stall), 32'(got.stall));
    chk({got.tag, ".sel"}, 32'(out_fwd_sel), 32'(got.sel));
    chk({got.tag, ".op"}, out_op, got.op);
    chk({got.tag, ".stall_cnt"}, 32'(out_stall_cnt), 32'(got.scnt));
    chk({got.tag, ".fwd_cnt"}, 32'(out_fwd_cnt), 32'(got.fcnt));
    exp_scnt = sat15(exp_scnt + int'(exp_stall));
    exp_fcnt = sat15(exp_fcnt + nfwd);
    mem_next = 16'($urandom);
    wb_next  = 16'($urandom);
  endtask

  task automatic nop(input string tag, input logic exp_stall, input logic [3:0] exp_sel);
    cyc(tag, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, exp_stall, exp_sel);
  endtask

  initial begin
    mem_next = 16'($urandom);
    wb_next  = 16'($urandom);

    // Reset with random inputs
    in_rst         = 1'b0;
    in_id_valid    = 1'($urandom);
    in_id_src      = 8'($urandom);
    in_id_src_used = 2'($urandom);
    in_id_dst      = 4'($urandom);
    in_id_wr       = 1'($urandom);
    in_id_load     = 1'($urandom);
    in_flush       = 1'($urandom);
    in_ex_rf_data  = $urandom;
    in_mem_data    = 16'($urandom);
    in_wb_data     = 16'($urandom);
    #1;
    chk("rst.stall", 32'(out_stall), 32'd0);
    chk("rst.sel", 32'(out_fwd_sel), 32'd0);
    chk("rst.op", out_op, in_ex_rf_data);
    chk("rst.stall_cnt", 32'(out_stall_cnt), 32'd0);
    chk("rst.fwd_cnt", 32'(out_fwd_cnt), 32'd0);
    in_id_valid = 1'b0; in_id_src_used = 2'b00; in_id_wr = 1'b0;
    in_id_load = 1'b0; in_flush = 1'b0;
    #1 in_rst = 1'b1;

    // ALU back-to-back: add r2, then read r2/r3
    cyc("b2b.i1", 1, 4'd0, 4'd0, 2'b00, 4'd2, 1, 0, 0, 0, 4'h0);
    cyc("b2b.i2", 1, 4'd2, 4'd3, 2'b11, 4'd7, 1, 0, 0, 0, 4'h0);
    mem_next = 16'h0FC0;
    nop("b2b.ex", 0, 4'h1);
    nop("b2b.drain", 0, 4'h0);

    // Two writers of r6: MEM (newest) must win over WB
    cyc("prio.i1", 1, 4'd0, 4'd0, 2'b00, 4'd6, 1, 0, 0, 0, 4'h0);
    cyc("prio.i2", 1, 4'd0, 4'd0, 2'b00, 4'd6, 1, 0, 0, 0, 4'h0);
    cyc("prio.i3", 1, 4'd6, 4'd1, 2'b11, 4'd8, 0, 0, 0, 0, 4'h0);
    nop("prio.ex", 0, 4'h1);
    nop("prio.drain", 0, 4'h0);

    // Distance 2 through a nop: WB forward on operand 1
    cyc("d2.i1", 1, 4'd0, 4'd0, 2'b00, 4'd4, 1, 0, 0, 0, 4'h0);
    nop("d2.nop", 0, 4'h0);
    cyc("d2.i3", 1, 4'd5, 4'd4, 2'b11, 4'd9, 1, 0, 0, 0, 4'h0);
    wb_next = 16'h0FFF;
    nop("d2.ex", 0, 4'h8);
    nop("d2.drain", 0, 4'h0);

    // Load-use: one stall, then WB forward of the load data
    cyc("lu.load", 1, 4'd0, 4'd0, 2'b00, 4'd1, 1, 1, 0, 0, 4'h0);
    cyc("lu.stall", 1, 4'd1, 4'd2, 2'b11, 4'd10, 1, 0, 0, 1, 4'h0);
    cyc("lu.held", 1, 4'd1, 4'd2, 2'b11, 4'd10, 1, 0, 0, 0, 4'h0);
    wb_next = 16'h1554;
    nop("lu.ex", 0, 4'h2);
    nop("lu.drain", 0, 4'h0);

    // r0 never forwards and never stalls
    cyc("r0.alu", 1, 4'd0, 4'd0, 2'b00, 4'd0, 1, 0, 0, 0, 4'h0);
    cyc("r0.load", 1, 4'd0, 4'd0, 2'b00, 4'd0, 1, 1, 0, 0, 4'h0);
    cyc("r0.use", 1, 4'd0, 4'd0, 2'b11, 4'd11, 1, 0, 0, 0, 4'h0);
    nop("r0.ex", 0, 4'h0);
    nop("r0.drain", 0, 4'h0);

    // Flush overrides stall, squashes the ID instr, lets the load advance
    cyc("fl.load", 1, 4'd0, 4'd0, 2'b00, 4'd1, 1, 1, 0, 0, 4'h0);
    cyc("fl.flush", 1, 4'd1, 4'd0, 2'b01, 4'd5, 1, 1, 1, 0, 4'h0);
    cyc("fl.next", 1, 4'd5, 4'd1, 2'b11, 4'd12, 0, 0, 0, 0, 4'h0);
    nop("fl.ex", 0, 4'h8);
    nop("fl.drain", 0, 4'h0);

    // Chain of 20 load-use pairs drives both counters into saturation
    cyc("sat.ld0", 1, 4'd0, 4'd0, 2'b00, 4'd1, 1, 1, 0, 0, 4'h0);
    for (int i = 1; i <= 20; i++) begin
      cyc($sformatf("sat.a%0d", i), 1, 4'(((i - 1) % 2) + 1), 4'd0, 2'b01,
          4'((i % 2) + 1), 1, 1, 0, 1, (i == 1) ? 4'h0 : 4'h2);
      cyc($sformatf("sat.b%0d", i), 1, 4'(((i - 1) % 2) + 1), 4'd0, 2'b01,
          4'((i % 2) + 1), 1, 1, 0, 0, 4'h0);
    end
    nop("sat.tail", 0, 4'h2);

    // Asynchronous reset in mid-cycle
    in_rst = 1'b0;
    #1;
    chk("mrst.stall", 32'(out_stall), 32'd0);
    chk("mrst.sel", 32'(out_fwd_sel), 32'd0);
    chk("mrst.op", out_op, in_ex_rf_data);
    chk("mrst.stall_cnt", 32'(out_stall_cnt), 32'd0);
    chk("mrst.fwd_cnt", 32'(out_fwd_cnt), 32'd0);
    exp_scnt = 0;
    exp_fcnt = 0;
    #1 in_rst = 1'b1;

    // Forwarding still works after reset
    cyc("post.i1", 1, 4'd0, 4'd0, 2'b00, 4'd3, 1, 0, 0, 0, 4'h0);
    cyc("post.i2", 1, 4'd4, 4'd3, 2'b11, 4'd7, 1, 0, 0, 0, 4'h0);
    mem_next = 16'hABCD;
    nop("post.ex", 0, 4'h4);
    nop("post.drain", 0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
